// File: rtl/alu_board_ctrl_if.sv
// Board-side bundle for alu_board_ctrl: switch/key inputs, ALU operand/result
// wiring and seven-segment outputs. The board/bench side uses master; the controller uses slave.
interface alu_board_ctrl_if #(
    parameter int DATA_W     = 32,
    parameter int SW_W       = 16,
    parameter int NUM_DIGITS = 8
);
    logic [3:0]              key_n;
    logic [SW_W-1:0]         sw_data;
    logic                    sw_ext;
    logic [DATA_W-1:0]       result;
    logic [DATA_W-1:0]       portA;
    logic [DATA_W-1:0]       portB;
    logic [3:0]              aluop;
    logic [1:0]              disp_mode;
    logic [7*NUM_DIGITS-1:0] hex_n;

    modport master (
        output key_n, sw_data, sw_ext, result,
        input  portA, portB, aluop, disp_mode, hex_n
    );

    modport slave (
        input  key_n, sw_data, sw_ext, result,
        output portA, portB, aluop, disp_mode, hex_n
    );
endinterface

// File: rtl/alu_board_ctrl.sv
// DE2 board controller for the ALU: debounced key commands load operands, step the
// opcode and cycle the display source. Optional macro ALU_BOARD_LZB_EN enables leading-zero blanking.
module alu_board_ctrl #(
    parameter int DATA_W     = 32,
    parameter int SW_W       = 16,
    parameter int NUM_DIGITS = 8,
    parameter int DB_CYCLES  = 500000
) (
    input  logic              CLOCK_50,
    input  logic              RST,
    alu_board_ctrl_if.slave   bus
);
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam int SRC_W = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        MODE_RESULT = 2'd0,
        MODE_OPA    = 2'd1,
        MODE_OPB    = 2'd2,
        MODE_BAD    = 2'd3
    } mode_t;

    logic [3:0]        press;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] port_a_reg;
    logic [DATA_W-1:0] port_b_reg;
    logic [3:0]        aluop_reg;
    mode_t             mode_reg, mode_next;
    logic [SRC_W-1:0]  src;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h27;  4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
    endfunction

    // Per-key synchroniser + debouncer; a press pulse fires only on the debounced fall.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            logic             s1_reg, s2_reg, db_reg, press_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge CLOCK_50 or posedge RST) begin
                if (RST) begin
                    s1_reg    <= 1'b1;
                    s2_reg    <= 1'b1;
                    db_reg    <= 1'b1;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    s1_reg    <= bus.key_n[gi];
                    s2_reg    <= s1_reg;
                    press_reg <= 1'b0;
                    if (s2_reg != db_reg) begin
                        if (cnt_reg == CNT_MAX) begin
                            db_reg    <= s2_reg;
                            cnt_reg   <= '0;
                            press_reg <= ~s2_reg;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    always_comb begin
        operand              = {DATA_W{bus.sw_ext}};
        operand[SW_W-1:0]    = bus.sw_data;
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            port_a_reg <= '0;
            port_b_reg <= '0;
            aluop_reg  <= '0;
        end else begin
            if (press[0]) port_a_reg <= operand;
            if (press[1]) port_b_reg <= operand;
            if (press[2]) aluop_reg  <= aluop_reg + 4'd1;
        end
    end

    // Display mode FSM: state register
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) mode_reg <= MODE_RESULT;
        else     mode_reg <= mode_next;
    end

    // Display mode FSM: next state
    always_comb begin
        mode_next = mode_reg;
        case (mode_reg)
            MODE_RESULT: if (press[3]) mode_next = MODE_OPA;
            MODE_OPA:    if (press[3]) mode_next = MODE_OPB;
            MODE_OPB:    if (press[3]) mode_next = MODE_RESULT;
            default:     mode_next = MODE_RESULT;
        endcase
    end

    // Display mode FSM: outputs (display source select)
    always_comb begin
        src = '0;
        case (mode_reg)
            MODE_OPA: src[DATA_W-1:0] = port_a_reg;
            MODE_OPB: src[DATA_W-1:0] = port_b_reg;
            default:  src[DATA_W-1:0] = bus.result;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            logic [6:0] seg_next;
            logic [6:0] seg_reg;

            assign nib = src[4*gi +: 4];
`ifdef ALU_BOARD_LZB_EN
            logic upper_nz;
            assign upper_nz = |src[SRC_W-1:4*gi];
            // Digit 0 is never blanked so a zero value still shows "0".
            assign seg_next = (gi != 0 && !upper_nz) ? 7'h7F : glyph(nib);
`else
            assign seg_next = glyph(nib);
`endif
            always_ff @(posedge CLOCK_50 or posedge RST) begin
                if (RST) seg_reg <= 7'h7F;
                else     seg_reg <= seg_next;
            end

            assign bus.hex_n[7*gi +: 7] = seg_reg;
        end
    endgenerate

    assign bus.portA     = port_a_reg;
    assign bus.portB     = port_b_reg;
    assign bus.aluop     = aluop_reg;
    assign bus.disp_mode = mode_reg;
endmodule
